// File: rtl/ingress_rst_seq_pkg.sv
// Shared types and default timing for the ingress power/clock/reset sequencer.
package ingress_rst_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    CLK_EN  = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    ACTIVE  = 3'd4,
    DRAIN   = 3'd5
  } rst_state_e;

  // Moore decode of one state onto the domain controls
  typedef struct packed {
    logic en;
    logic cr;
    logic sr;
    logic qreq;
    logic done;
  } dom_ctrl_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CLK_SETTLE    = 8;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_STAGGER       = 4;
  localparam int DEF_DRAIN_TIMEOUT = 256;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ingress_rst_seq_if.sv
// Software-reset handshake, interrupt and domain-control bundle of the sequencer.
interface ingress_rst_seq_if;
  logic sw_reset_req;
  logic quiesce_ack;
  logic int_clear;
  logic enable_secondary_clock;
  logic core_reset;
  logic secondary_reset;
  logic quiesce_req;
  logic reset_done;
  logic ingress_int;

  modport slave (
    input  sw_reset_req, quiesce_ack, int_clear,
    output enable_secondary_clock, core_reset, secondary_reset,
           quiesce_req, reset_done, ingress_int
  );

  modport master (
    output sw_reset_req, quiesce_ack, int_clear,
    input  enable_secondary_clock, core_reset, secondary_reset,
           quiesce_req, reset_done, ingress_int
  );
endinterface

// File: rtl/ingress_rst_seq_sync.sv
// N-flop level synchroniser, cleared to 0 by the async reset.
module ingress_sync_cell #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];
endmodule

// File: rtl/ingress_rst_seq.sv
// Power-good driven bring-up sequencer with software reset via quiesce handshake.
module ingress_rst_seq
  import ingress_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CLK_SETTLE    = DEF_CLK_SETTLE,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int STAGGER       = DEF_STAGGER,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic              primary_clock,
  input  logic              primary_reset_n,
  input  logic              power_good,
  ingress_rst_seq_if.slave  ctl,
  output logic [2:0]        state_o
);
  localparam int CNT_W = $clog2(max4(CLK_SETTLE, HOLD_CYCLES, STAGGER, DRAIN_TIMEOUT)) + 1;

  logic             pg_s;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_q, int_d;
  logic             timeout_set;
  dom_ctrl_t        ctrl;

  ingress_sync_cell #(.N(SYNC_STAGES)) u_pg_sync (
    .clk_i (primary_clock),
    .rst_ni(primary_reset_n),
    .d_i   (power_good),
    .q_o   (pg_s)
  );

  // Each timed state runs N cycles: load N-1 on entry, leave when 0
  function automatic logic [CNT_W-1:0] load_val(input rst_state_e s);
    case (s)
      CLK_EN:  return CNT_W'(CLK_SETTLE - 1);
      HOLD:    return CNT_W'(HOLD_CYCLES - 1);
      RELEASE: return CNT_W'(STAGGER - 1);
      DRAIN:   return CNT_W'(DRAIN_TIMEOUT - 1);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge primary_clock or negedge primary_reset_n) begin
    if (!primary_reset_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    case (state_q)
      OFF:     if (pg_s)          state_d = CLK_EN;
      CLK_EN:  if (cnt_q == '0)   state_d = HOLD;
      HOLD:    if (cnt_q == '0)   state_d = RELEASE;
      RELEASE: if (cnt_q == '0)   state_d = ACTIVE;
      ACTIVE:  if (ctl.sw_reset_req) state_d = DRAIN;
      DRAIN: begin
        if (ctl.quiesce_ack) begin
          state_d = HOLD;
        end else if (cnt_q == '0) begin
          state_d     = HOLD;
          timeout_set = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    // Loss of power beats every other transition, including a pending timeout
    if (!pg_s) begin
      state_d     = OFF;
      timeout_set = 1'b0;
    end

    if (state_d != state_q) cnt_d = load_val(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
    else                    cnt_d = '0;

    if (timeout_set)        int_d = 1'b1;
    else if (ctl.int_clear) int_d = 1'b0;
    else                    int_d = int_q;
  end

  always_comb begin
    ctrl = '{en: 1'b0, cr: 1'b1, sr: 1'b1, qreq: 1'b0, done: 1'b0};
    case (state_q)
      CLK_EN, HOLD: ctrl = '{en: 1'b1, cr: 1'b1, sr: 1'b1, qreq: 1'b0, done: 1'b0};
      RELEASE:      ctrl = '{en: 1'b1, cr: 1'b0, sr: 1'b1, qreq: 1'b0, done: 1'b0};
      ACTIVE:       ctrl = '{en: 1'b1, cr: 1'b0, sr: 1'b0, qreq: 1'b0, done: 1'b1};
      DRAIN:        ctrl = '{en: 1'b1, cr: 1'b0, sr: 1'b0, qreq: 1'b1, done: 1'b0};
      default:      ctrl = '{en: 1'b0, cr: 1'b1, sr: 1'b1, qreq: 1'b0, done: 1'b0};
    endcase
  end

  assign ctl.enable_secondary_clock = ctrl.en;
  assign ctl.core_reset             = ctrl.cr;
  assign ctl.secondary_reset        = ctrl.sr;
  assign ctl.quiesce_req            = ctrl.qreq;
  assign ctl.reset_done             = ctrl.done;
  assign ctl.ingress_int            = int_q;
  assign state_o                    = state_q;
endmodule

// File: tb/tb_ingress_rst_seq.sv
// Directed bench for ingress_rst_seq: expected snapshots are queued per cycle and checked on the falling edge.
module tb_ingress_rst_seq;
  localparam logic [2:0] S_OFF = 3'd0, S_CLK_EN = 3'd1, S_HOLD = 3'd2,
                         S_RELEASE = 3'd3, S_ACTIVE = 3'd4, S_DRAIN = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pg;
  logic [2:0] st;

  ingress_rst_seq_if bus();

  ingress_rst_seq dut (
    .primary_clock  (clk),
    .primary_reset_n(rst_n),
    .power_good     (pg),
    .ctl            (bus),
    .state_o        (st)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  int t0  = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [8:0] exp;
  } sb_t;
  sb_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int now();
    return cnt - t0;
  endfunction

  // {state, en, core_reset, sec_reset, quiesce_req, reset_done, ingress_int}
  function automatic logic [8:0] exp_vec(input logic [2:0] s, input logic iv);
    logic [4:0] o;
    case (s)
      S_OFF:            o = 5'b01100;
      S_CLK_EN, S_HOLD: o = 5'b11100;
      S_RELEASE:        o = 5'b10100;
      S_ACTIVE:         o = 5'b10001;
      S_DRAIN:          o = 5'b10010;
      default:          o = 5'b01100;
    endcase
    return {s, o, iv};
  endfunction

  task automatic chk(input string tag, input logic [8:0] e);
    logic [8:0] o;
    o = {st, bus.enable_secondary_clock, bus.core_reset, bus.secondary_reset,
         bus.quiesce_req, bus.reset_done, bus.ingress_int};
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [2:0] s, input logic iv);
    sb_t e;
    e.cyc = c;
    e.tag = tag;
    e.exp = exp_vec(s, iv);
    sb.push_back(e);
  endtask

  task automatic at_cycle(input int c);
    while (now() < c) @(negedge clk);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      at_cycle(e.cyc);
      if (now() != e.cyc) begin
        n_bad++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.tag, now(), e.cyc);
      end
      chk(e.tag, e.exp);
    end
  endtask

  task automatic pulse_sw();
    bus.sw_reset_req = 1'b1;
    @(negedge clk);
    bus.sw_reset_req = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.int_clear = 1'b1;
    @(negedge clk);
    bus.int_clear = 1'b0;
  endtask

  initial begin
    int b, r;
    rst_n = 1'b1;
    pg    = 1'b1;
    bus.sw_reset_req = 1'b0;
    bus.quiesce_ack  = 1'b0;
    bus.int_clear    = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk("reset_values", exp_vec(S_OFF, 1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cnt;

    // power-on bring-up with power_good already high
    push(2,  "bringup_off",      S_OFF,     1'b0);
    push(3,  "bringup_clk_en",   S_CLK_EN,  1'b0);
    push(10, "bringup_clk_last", S_CLK_EN,  1'b0);
    push(11, "bringup_hold",     S_HOLD,    1'b0);
    push(26, "bringup_hold_end", S_HOLD,    1'b0);
    push(27, "bringup_core_rel", S_RELEASE, 1'b0);
    push(30, "bringup_stagger",  S_RELEASE, 1'b0);
    push(31, "bringup_active",   S_ACTIVE,  1'b0);
    drain();

    // software reset, ack after 5 drain cycles
    b = 33;
    at_cycle(b);
    pulse_sw();
    push(b + 1, "swr_drain",       S_DRAIN, 1'b0);
    push(b + 5, "swr_drain_last",  S_DRAIN, 1'b0);
    drain();
    bus.quiesce_ack = 1'b1;
    push(b + 6,  "swr_hold",       S_HOLD,    1'b0);
    push(b + 21, "swr_hold_end",   S_HOLD,    1'b0);
    push(b + 22, "swr_core_rel",   S_RELEASE, 1'b0);
    push(b + 25, "swr_stagger",    S_RELEASE, 1'b0);
    push(b + 26, "swr_active",     S_ACTIVE,  1'b0);
    at_cycle(b + 6);
    bus.quiesce_ack = 1'b0;
    drain();

    // software reset with no ack: timeout sets the interrupt
    b = now() + 2;
    at_cycle(b);
    pulse_sw();
    push(b + 1,   "to_drain",      S_DRAIN,   1'b0);
    push(b + 256, "to_drain_last", S_DRAIN,   1'b0);
    push(b + 257, "to_hold_int",   S_HOLD,    1'b1);
    push(b + 273, "to_release",    S_RELEASE, 1'b1);
    push(b + 277, "to_active",     S_ACTIVE,  1'b1);
    drain();

    // power loss mid-DRAIN keeps the interrupt
    b = now() + 2;
    at_cycle(b);
    pulse_sw();
    push(b + 1, "pgd_drain", S_DRAIN, 1'b1);
    drain();
    at_cycle(b + 10);
    pg = 1'b0;
    push(b + 12, "pgd_still_drain", S_DRAIN, 1'b1);
    push(b + 13, "pgd_off",         S_OFF,   1'b1);
    push(b + 15, "pgd_off_hold",    S_OFF,   1'b1);
    drain();

    // restore, sw request in CLK_EN ignored, then drop power mid-HOLD
    r = now();
    pg = 1'b1;
    push(r + 2, "rst1_off",    S_OFF,    1'b1);
    push(r + 3, "rst1_clk_en", S_CLK_EN, 1'b1);
    drain();
    at_cycle(r + 5);
    pulse_sw();
    push(r + 10, "rst1_swr_ign", S_CLK_EN, 1'b1);
    push(r + 11, "rst1_hold",    S_HOLD,   1'b1);
    drain();
    at_cycle(r + 15);
    pg = 1'b0;
    push(r + 17, "pgh_still_hold", S_HOLD, 1'b1);
    push(r + 18, "pgh_off",        S_OFF,  1'b1);
    drain();

    // full bring-up again, sw request in HOLD ignored
    at_cycle(now() + 2);
    r = now();
    pg = 1'b1;
    push(r + 3,  "rst2_clk_en", S_CLK_EN, 1'b1);
    push(r + 11, "rst2_hold",   S_HOLD,   1'b1);
    drain();
    at_cycle(r + 15);
    pulse_sw();
    push(r + 26, "rst2_hold_end",  S_HOLD,    1'b1);
    push(r + 27, "rst2_core_rel",  S_RELEASE, 1'b1);
    push(r + 30, "rst2_stagger",   S_RELEASE, 1'b1);
    push(r + 31, "rst2_active",    S_ACTIVE,  1'b1);
    push(r + 33, "rst2_no_drain",  S_ACTIVE,  1'b1);
    drain();

    // int_clear drops the sticky interrupt
    b = now();
    push(b + 1, "int_clear", S_ACTIVE, 1'b0);
    pulse_clr();
    drain();

    // ack arrives in the timeout cycle: no interrupt
    b = now() + 1;
    at_cycle(b);
    pulse_sw();
    push(b + 1, "ackto_drain", S_DRAIN, 1'b0);
    drain();
    at_cycle(b + 256);
    bus.quiesce_ack = 1'b1;
    push(b + 257, "ackto_hold_noint", S_HOLD, 1'b0);
    drain();
    bus.quiesce_ack = 1'b0;
    push(b + 273, "ackto_release", S_RELEASE, 1'b0);
    push(b + 277, "ackto_active",  S_ACTIVE,  1'b0);
    drain();

    // int_clear in the timeout-set cycle: set wins
    b = now() + 1;
    at_cycle(b);
    pulse_sw();
    at_cycle(b + 256);
    bus.int_clear = 1'b1;
    push(b + 256, "setclr_drain", S_DRAIN, 1'b0);
    push(b + 257, "setclr_set",   S_HOLD,  1'b1);
    drain();
    bus.int_clear = 1'b0;
    push(b + 260, "setclr_sticky", S_HOLD,   1'b1);
    push(b + 277, "setclr_active", S_ACTIVE, 1'b1);
    drain();

    // async reset while in RELEASE
    b = now() + 1;
    at_cycle(b);
    pulse_sw();
    at_cycle(b + 3);
    bus.quiesce_ack = 1'b1;
    at_cycle(b + 4);
    bus.quiesce_ack = 1'b0;
    push(b + 20, "arst_release", S_RELEASE, 1'b1);
    drain();
    at_cycle(b + 21);
    #2 rst_n = 1'b0;
    #1 chk("arst_async", exp_vec(S_OFF, 1'b0));
    @(negedge clk);
    chk("arst_held", exp_vec(S_OFF, 1'b0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
